serial_parity_checker: RTL and testbench

- Receives a serial bitstream framed by a start strobe and rebuilds DATA_W-bit words.
- Accumulates XOR parity over the data bits and checks it against a trailing parity bit.
- Sits directly downstream of the XOR gate stage; it uses the XOR reduction in a clocked FSM.
- Drives a one-cycle result pulse to the consuming logic.

---
 rtl/serial_parity_checker.sv | 129 ++++++++++++
 tb/tb_serial_parity_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - serial word deserialiser with trailing parity-bit check
module serial_parity_checker #(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_start,
  input  logic              in_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  // cnt holds the index of the next data bit; it must be able to represent DATA_W-1
  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic              ODD_BIT  = (ODD != 0);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  // a one-bit word has no further data bits, so the start bit leads straight to parity
  localparam state_t LOAD_STATE = (DATA_W == 1) ? PARITY : DATA;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                perr_q, perr_d;
  logic                ov_q, ov_d;
  logic                fe_q, fe_d;

  logic                start_hit;
  logic                bit_hit;

  assign start_hit = in_valid & in_start;
  assign bit_hit   = in_valid & ~in_start;

  // next-state and registered-output decode; a start strobe reloads in every state
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ov_d    = 1'b0;
    fe_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // lone data bits outside a frame are dropped
      end
      DATA: begin
        if (bit_hit) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              sr_d[i] = in_bit;
            end
          end
          acc_d = acc_q ^ in_bit;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_hit) begin
          data_d  = sr_q;
          perr_d  = acc_q ^ in_bit ^ ODD_BIT;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // a start strobe mid-frame discards the partial word and flags the abort
    if (start_hit) begin
      fe_d    = (state_q != IDLE);
      sr_d    = '0;
      sr_d[0] = in_bit;
      acc_d   = in_bit;
      cnt_d   = CNT_W'(1);
      state_d = LOAD_STATE;
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ov_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ov_q    <= ov_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out   = data_q;
  assign parity_err = perr_q;
  assign out_valid  = ov_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb/tb_serial_parity_checker.sv - randomized bench for serial_parity_checker against a frame-level model
module tb_serial_parity_checker;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_start;
  logic              in_bit;

  logic [DATA_W-1:0] dout0, dout1;
  logic              ov0, ov1, perr0, perr1, fe0, fe1, busy0, busy1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_frames = 0;

  // frame-level reference: the bits received so far in the open frame
  logic              q_bits[$];
  logic              active = 1'b0;
  logic              exp_ov = 1'b0;
  logic              exp_fe = 1'b0;
  logic              exp_busy = 1'b0;
  logic [DATA_W-1:0] exp_data = '0;
  logic              exp_perr0 = 1'b0;
  logic              exp_perr1 = 1'b0;

  serial_parity_checker #(.DATA_W(DATA_W), .ODD(0)) u_even (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start), .in_bit(in_bit),
    .data_out(dout0), .out_valid(ov0), .parity_err(perr0), .frame_err(fe0), .busy(busy0)
  );

  serial_parity_checker #(.DATA_W(DATA_W), .ODD(1)) u_odd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_start(in_start), .in_bit(in_bit),
    .data_out(dout1), .out_valid(ov1), .parity_err(perr1), .frame_err(fe1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // what the outputs must show after one clock edge with these inputs
  task automatic model_edge(input logic v, input logic s, input logic b, input logic r);
    int ones;
    if (r) begin
      q_bits.delete();
      active = 1'b0; exp_ov = 1'b0; exp_fe = 1'b0; exp_busy = 1'b0;
      exp_data = '0; exp_perr0 = 1'b0; exp_perr1 = 1'b0;
      return;
    end
    exp_ov = 1'b0;
    exp_fe = 1'b0;
    if (v && s) begin
      exp_fe = active;
      q_bits.delete();
      q_bits.push_back(b);
      active = 1'b1;
    end else if (v && active) begin
      q_bits.push_back(b);
      if (q_bits.size() == DATA_W + 1) begin
        for (int i = 0; i < DATA_W; i++) exp_data[i] = q_bits[i];
        ones = $countones(exp_data) + int'(q_bits[DATA_W]);
        exp_perr0 = (ones % 2) != 0;
        exp_perr1 = (ones % 2) != 1;
        exp_ov = 1'b1;
        active = 1'b0;
        n_frames++;
      end
    end
    exp_busy = active;
  endtask

  task automatic step(input logic v, input logic s, input logic b, input logic r);
    in_valid = v; in_start = s; in_bit = b; rst = r;
    @(posedge clk);
    model_edge(v, s, b, r);
    #1;
    check("even_out_valid", 32'(ov0), 32'(exp_ov));
    check("even_frame_err", 32'(fe0), 32'(exp_fe));
    check("even_busy", 32'(busy0), 32'(exp_busy));
    check("even_data_out", 32'(dout0), 32'(exp_data));
    check("even_parity_err", 32'(perr0), 32'(exp_perr0));
    check("odd_out_valid", 32'(ov1), 32'(exp_ov));
    check("odd_frame_err", 32'(fe1), 32'(exp_fe));
    check("odd_busy", 32'(busy1), 32'(exp_busy));
    check("odd_data_out", 32'(dout1), 32'(exp_data));
    check("odd_parity_err", 32'(perr1), 32'(exp_perr1));
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w, input logic p, input int gap);
    for (int i = 0; i < DATA_W; i++) begin
      step(1'b1, (i == 0), w[i], 1'b0);
      repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, p, 1'b0);
  endtask

  initial begin
    logic v, s, b, r;
    in_valid = 1'b0; in_start = 1'b0; in_bit = 1'b0; rst = 1'b1;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_data", 32'(dout0), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    send_frame(8'hA5, 1'b0, 0);
    check("a5_pulse", 32'(ov0), 32'd1);
    check("a5_data", 32'(dout0), 32'hA5);
    check("a5_perr", 32'(perr0), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("a5_pulse_gone", 32'(ov0), 32'd0);
    check("a5_data_hold", 32'(dout0), 32'hA5);

    send_frame(8'h07, 1'b0, 0);
    check("x07_p0_perr", 32'(perr0), 32'd1);
    send_frame(8'h07, 1'b1, 0);
    check("x07_p1_perr", 32'(perr0), 32'd0);

    send_frame(8'h3C, 1'b0, 3);
    check("stall_data", 32'(dout0), 32'h3C);
    check("stall_perr", 32'(perr0), 32'd0);

    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("abort_frame_err", 32'(fe0), 32'd1);
    for (int i = 1; i < DATA_W; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_data", 32'(dout0), 32'hFF);
    check("abort_perr", 32'(perr0), 32'd0);

    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_data", 32'(dout0), 32'd0);
    send_frame(8'h81, 1'b0, 0);
    check("post_rst_data", 32'(dout0), 32'h81);
    check("post_rst_perr", 32'(perr0), 32'd0);

    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h00, 1'b0, 0);
    check("b2b_second_pulse", 32'(ov0), 32'd1);
    check("b2b_second_perr", 32'(perr0), 32'd0);

    send_frame(8'h00, 1'b1, 0);
    check("odd_x00_perr", 32'(perr1), 32'd0);
    check("even_x00_p1_perr", 32'(perr0), 32'd1);

    n_frames = 0;
    for (int c = 0; c < 3000; c++) begin
      v = ($urandom % 4) != 0;
      s = active ? (($urandom % 40) == 0) : (($urandom % 3) == 0);
      b = 1'($urandom);
      r = ($urandom % 300) == 0;
      step(v, s, b, r);
    end
    check("rand_frames_seen", 32'(n_frames > 20), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
